// File: rtl/mcu_pkg.sv
// Shared encodings for the 8-bit MCU control sequencer: opcodes, ALU ops, states, writeback mux codes.
// MCU_IRQ_EN adds the IRQ state to the state encoding.
package mcu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_MOV   = 4'h6;
    localparam logic [3:0] OP_LDI   = 4'h7;
    localparam logic [3:0] OP_DEC   = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_IN    = 4'hB;
    localparam logic [3:0] OP_OUT   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_JNZ   = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_MOV = 4'd5;
    localparam logic [3:0] ALU_LDI = 4'd6;
    localparam logic [3:0] ALU_DEC = 4'd7;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;
    localparam logic [1:0] MUX_IO  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_MEM    = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
`ifdef MCU_IRQ_EN
        ,
        ST_IRQ    = 3'd7
`endif
    } state_e;

endpackage

// File: rtl/mcu_alu_op_map.sv
// Combinational opcode -> ALU operation mapping with illegal-opcode flag; shared with trace tooling.
module mcu_alu_op_map
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALU_OP_W-1:0] alu_op_c,
    output logic                illegal_c
);

    // Only the low nibble is defined; any upper bit set is an illegal encoding.
    assign illegal_c = (opcode >> 4) != '0;

    always_comb begin
        alu_op_c = ALU_OP_W'(ALU_ADD);
        if (!illegal_c) begin
            case (opcode[3:0])
                OP_ADD:  alu_op_c = ALU_OP_W'(ALU_ADD);
                OP_SUB:  alu_op_c = ALU_OP_W'(ALU_SUB);
                OP_AND:  alu_op_c = ALU_OP_W'(ALU_AND);
                OP_OR:   alu_op_c = ALU_OP_W'(ALU_OR);
                OP_XOR:  alu_op_c = ALU_OP_W'(ALU_XOR);
                OP_MOV:  alu_op_c = ALU_OP_W'(ALU_MOV);
                OP_LDI:  alu_op_c = ALU_OP_W'(ALU_LDI);
                OP_DEC:  alu_op_c = ALU_OP_W'(ALU_DEC);
                default: alu_op_c = ALU_OP_W'(ALU_ADD);
            endcase
        end
    end

endmodule

// File: rtl/mcu_ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit MCU with memory wait states, branches, HLT and illegal-op detect.
// Define MCU_IRQ_EN to add the irq/irq_ack ports and the IRQ vector state.
module mcu_ctrl_seq
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imm_mode,
    input  logic                zero_flag,
    input  logic                mem_ready,
`ifdef MCU_IRQ_EN
    input  logic                irq,
    output logic                irq_ack,
`endif
    output logic                reg_write,
    output logic                load_a,
    output logic                load_b,
    output logic                load_c,
    output logic                load_ir,
    output logic                load_flags,
    output logic                load_data_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                pc_sel,
    output logic [1:0]          mux1_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                io_enable,
    output logic                io_write_enable,
    output logic                halted,
    output logic                illegal_op,
    output logic                mem_timeout
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_nxt;
    logic [3:0]          op_q;
    logic [ALU_OP_W-1:0] map_alu_op;
    logic                map_illegal;
    logic                timeout;

    mcu_alu_op_map #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_map (
        .opcode    (opcode),
        .alu_op_c  (map_alu_op),
        .illegal_c (map_illegal)
    );

    assign timeout = (wait_cnt == CNT_W'(WAIT_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            alu_op   <= '0;
            op_q     <= OP_NOP;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == ST_DECODE) begin
                alu_op <= map_alu_op;
                op_q   <= opcode[3:0];
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_nxt        = '0;
        reg_write       = 1'b0;
        load_a          = 1'b0;
        load_b          = 1'b0;
        load_c          = 1'b0;
        load_ir         = 1'b0;
        load_flags      = 1'b0;
        load_data_reg   = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        load_pc         = 1'b0;
        inc_pc          = 1'b0;
        pc_sel          = 1'b0;
        mux1_sel        = MUX_ALU;
        io_enable       = 1'b0;
        io_write_enable = 1'b0;
        halted          = 1'b0;
        illegal_op      = 1'b0;
        mem_timeout     = 1'b0;
`ifdef MCU_IRQ_EN
        irq_ack         = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                if (timeout) begin
                    mem_timeout = 1'b1;
`ifdef MCU_IRQ_EN
                end else if (irq && wait_cnt == '0) begin
                    state_nxt = ST_IRQ;
`endif
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        load_ir   = 1'b1;
                        inc_pc    = 1'b1;
                        state_nxt = ST_DECODE;
                    end else begin
                        wait_nxt = wait_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DECODE: begin
                if (map_illegal) begin
                    illegal_op = 1'b1;
                    state_nxt  = ST_FETCH;
                end else begin
                    case (opcode[3:0])
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_MOV, OP_LDI, OP_DEC:            state_nxt = ST_EXEC;
                        OP_LOAD, OP_STORE, OP_IN, OP_OUT:  state_nxt = ST_MEM;
                        OP_JMP, OP_JNZ:                    state_nxt = ST_BRANCH;
                        OP_HLT:                            state_nxt = ST_HALT;
                        default:                           state_nxt = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC: begin
                load_a    = 1'b1;
                load_b    = 1'b1;
                load_c    = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                reg_write = 1'b1;
                state_nxt = ST_FETCH;
                if (op_q == OP_LOAD) begin
                    mux1_sel = MUX_MEM;
                end else if (op_q == OP_IN) begin
                    mux1_sel = MUX_IO;
                end else begin
                    load_flags = (op_q != OP_MOV) && (op_q != OP_LDI);
                    mux1_sel   = (op_q == OP_LDI || imm_mode) ? MUX_IMM : MUX_ALU;
                end
            end
            ST_MEM: begin
                if (timeout) begin
                    mem_timeout = 1'b1;
                    state_nxt   = ST_FETCH;
                end else begin
                    case (op_q)
                        OP_LOAD:  mem_read = 1'b1;
                        OP_STORE: begin
                            mem_write     = 1'b1;
                            load_data_reg = 1'b1;
                        end
                        OP_IN:    io_enable = 1'b1;
                        default: begin
                            io_enable       = 1'b1;
                            io_write_enable = 1'b1;
                            load_data_reg   = 1'b1;
                        end
                    endcase
                    // Reads continue to writeback; writes retire straight to the next fetch.
                    if (mem_ready) begin
                        state_nxt = (op_q == OP_LOAD || op_q == OP_IN) ? ST_WB : ST_FETCH;
                    end else begin
                        wait_nxt = wait_cnt + CNT_W'(1);
                    end
                end
            end
            ST_BRANCH: begin
                if (op_q == OP_JMP || !zero_flag) begin
                    load_pc = 1'b1;
                    pc_sel  = 1'b1;
                end
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
`ifdef MCU_IRQ_EN
            ST_IRQ: begin
                load_pc   = 1'b1;
                irq_ack   = 1'b1;
                state_nxt = ST_FETCH;
            end
`endif
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mcu_ctrl_seq.sv
// Directed-vector bench for mcu_ctrl_seq (OPCODE_W=5); exercises the irq path when MCU_IRQ_EN is defined.
module tb_mcu_ctrl_seq;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned ALU_OP_W = 4;

    localparam logic [4:0] NOP = 5'h00, ADD = 5'h01, SUB = 5'h02, LDI = 5'h07, DEC = 5'h08;
    localparam logic [4:0] LOAD = 5'h09, STORE = 5'h0A, IN = 5'h0B, OUT = 5'h0C;
    localparam logic [4:0] JMP = 5'h0D, JNZ = 5'h0E, HLT = 5'h0F, BAD = 5'h1F;

    localparam logic [16:0] S_RW  = 17'd1 << 16, S_LA  = 17'd1 << 15, S_LB  = 17'd1 << 14;
    localparam logic [16:0] S_LC  = 17'd1 << 13, S_IR  = 17'd1 << 12, S_LF  = 17'd1 << 11;
    localparam logic [16:0] S_LDR = 17'd1 << 10, S_MR  = 17'd1 << 9,  S_MW  = 17'd1 << 8;
    localparam logic [16:0] S_LP  = 17'd1 << 7,  S_INC = 17'd1 << 6,  S_PS  = 17'd1 << 5;
    localparam logic [16:0] S_IOE = 17'd1 << 4,  S_IOW = 17'd1 << 3,  S_HLT = 17'd1 << 2;
    localparam logic [16:0] S_ILL = 17'd1 << 1,  S_TO  = 17'd1;
    localparam logic [16:0] S_FET = S_MR | S_IR | S_INC;
    localparam logic [16:0] S_EX  = S_LA | S_LB | S_LC;

    logic                clk = 1'b0;
    logic                reset;
    logic [OPCODE_W-1:0] opcode;
    logic                imm_mode, zero_flag, mem_ready;
    logic                reg_write, load_a, load_b, load_c, load_ir, load_flags, load_data_reg;
    logic                mem_read, mem_write, load_pc, inc_pc, pc_sel;
    logic [1:0]          mux1_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                io_enable, io_write_enable, halted, illegal_op, mem_timeout;
    logic [16:0]         strobes;
`ifdef MCU_IRQ_EN
    logic                irq, irq_ack;
`endif

    int vectors = 0;
    int miscompares = 0;

    mcu_ctrl_seq #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W),
        .WAIT_MAX (15)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode          (opcode),
        .imm_mode        (imm_mode),
        .zero_flag       (zero_flag),
        .mem_ready       (mem_ready),
`ifdef MCU_IRQ_EN
        .irq             (irq),
        .irq_ack         (irq_ack),
`endif
        .reg_write       (reg_write),
        .load_a          (load_a),
        .load_b          (load_b),
        .load_c          (load_c),
        .load_ir         (load_ir),
        .load_flags      (load_flags),
        .load_data_reg   (load_data_reg),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .load_pc         (load_pc),
        .inc_pc          (inc_pc),
        .pc_sel          (pc_sel),
        .mux1_sel        (mux1_sel),
        .alu_op          (alu_op),
        .io_enable       (io_enable),
        .io_write_enable (io_write_enable),
        .halted          (halted),
        .illegal_op      (illegal_op),
        .mem_timeout     (mem_timeout)
    );

    always #5 clk = ~clk;

    assign strobes = {reg_write, load_a, load_b, load_c, load_ir, load_flags, load_data_reg,
                      mem_read, mem_write, load_pc, inc_pc, pc_sel, io_enable, io_write_enable,
                      halted, illegal_op, mem_timeout};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check strobes, mux1_sel and alu_op at the falling edge, then step past the rising edge.
    task automatic cyc(input string tag, input logic [16:0] s, input logic [1:0] mux, input logic [3:0] alu);
        @(negedge clk);
        chk({tag, ".strobes"}, 32'(strobes), 32'(s));
        chk({tag, ".mux"}, 32'(mux1_sel), 32'(mux));
        chk({tag, ".alu"}, 32'(alu_op), 32'(alu));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = NOP; imm_mode = 1'b0; zero_flag = 1'b0; mem_ready = 1'b0;
`ifdef MCU_IRQ_EN
        irq = 1'b0;
`endif
        @(negedge clk);
        chk("rst_noready", 32'(strobes), 32'(S_MR));
        chk("rst_alu", 32'(alu_op), 32'd0);
        mem_ready = 1'b1;
        #1 chk("rst_ready", 32'(strobes), 32'(S_FET));
        @(posedge clk); #1;
        reset = 1'b0;

        // SUB then ADD with imm_mode: alu_op changes only after DECODE
        opcode = SUB;
        cyc("sub_f", S_FET, 2'b00, 4'd0);
        cyc("sub_d", 17'd0, 2'b00, 4'd0);
        cyc("sub_e", S_EX, 2'b00, 4'd1);
        cyc("sub_w", S_RW | S_LF, 2'b00, 4'd1);
        opcode = ADD; imm_mode = 1'b1;
        cyc("addi_f", S_FET, 2'b00, 4'd1);
        cyc("addi_d", 17'd0, 2'b00, 4'd1);
        cyc("addi_e", S_EX, 2'b00, 4'd0);
        cyc("addi_w", S_RW | S_LF, 2'b10, 4'd0);
        imm_mode = 1'b0; opcode = LDI;
        cyc("ldi_f", S_FET, 2'b00, 4'd0);
        cyc("ldi_d", 17'd0, 2'b00, 4'd0);
        cyc("ldi_e", S_EX, 2'b00, 4'd6);
        cyc("ldi_w", S_RW, 2'b10, 4'd6);

        // LOAD with three wait states in MEM
        opcode = LOAD;
        cyc("ld_f", S_FET, 2'b00, 4'd6);
        cyc("ld_d", 17'd0, 2'b00, 4'd6);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_wait", S_MR, 2'b00, 4'd0);
        mem_ready = 1'b1;
        cyc("ld_m", S_MR, 2'b00, 4'd0);
        cyc("ld_w", S_RW, 2'b01, 4'd0);

        opcode = STORE;
        cyc("st_f", S_FET, 2'b00, 4'd0);
        cyc("st_d", 17'd0, 2'b00, 4'd0);
        cyc("st_m", S_MW | S_LDR, 2'b00, 4'd0);
        opcode = OUT;
        cyc("out_f", S_FET, 2'b00, 4'd0);
        cyc("out_d", 17'd0, 2'b00, 4'd0);
        cyc("out_m", S_IOE | S_IOW | S_LDR, 2'b00, 4'd0);
        opcode = IN;
        cyc("in_f", S_FET, 2'b00, 4'd0);
        cyc("in_d", 17'd0, 2'b00, 4'd0);
        cyc("in_m", S_IOE, 2'b00, 4'd0);
        cyc("in_w", S_RW, 2'b11, 4'd0);

        // Branches
        opcode = JNZ; zero_flag = 1'b0;
        cyc("jnz0_f", S_FET, 2'b00, 4'd0);
        cyc("jnz0_d", 17'd0, 2'b00, 4'd0);
        cyc("jnz0_b", S_LP | S_PS, 2'b00, 4'd0);
        zero_flag = 1'b1;
        cyc("jnz1_f", S_FET, 2'b00, 4'd0);
        cyc("jnz1_d", 17'd0, 2'b00, 4'd0);
        cyc("jnz1_b", 17'd0, 2'b00, 4'd0);
        opcode = JMP;
        cyc("jmp_f", S_FET, 2'b00, 4'd0);
        cyc("jmp_d", 17'd0, 2'b00, 4'd0);
        cyc("jmp_b", S_LP | S_PS, 2'b00, 4'd0);
        zero_flag = 1'b0;

        opcode = NOP;
        cyc("nop_f", S_FET, 2'b00, 4'd0);
        cyc("nop_d", 17'd0, 2'b00, 4'd0);
        opcode = DEC;
        cyc("dec_f", S_FET, 2'b00, 4'd0);
        cyc("dec_d", 17'd0, 2'b00, 4'd0);
        cyc("dec_e", S_EX, 2'b00, 4'd7);
        cyc("dec_w", S_RW | S_LF, 2'b00, 4'd7);
        opcode = BAD;
        cyc("bad_f", S_FET, 2'b00, 4'd7);
        cyc("bad_d", S_ILL, 2'b00, 4'd7);

        // Fetch timeout: 15 wait cycles, then a single mem_timeout pulse
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc("to_wait", S_MR, 2'b00, 4'd0);
        cyc("to_pulse", S_TO, 2'b00, 4'd0);
        cyc("to_after", S_MR, 2'b00, 4'd0);

        // Reset mid-STORE drops mem_write without a clock edge
        mem_ready = 1'b1; opcode = STORE;
        cyc("rst_st_f", S_FET, 2'b00, 4'd0);
        cyc("rst_st_d", 17'd0, 2'b00, 4'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_st_m", 32'(strobes), 32'(S_MW | S_LDR));
        #1 reset = 1'b1;
        #1 chk("rst_st_drop", 32'(strobes), 32'(S_MR));
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;

        // HLT persists regardless of inputs until reset
        opcode = HLT;
        cyc("hlt_f", S_FET, 2'b00, 4'd0);
        cyc("hlt_d", 17'd0, 2'b00, 4'd0);
        cyc("hlt_1", S_HLT, 2'b00, 4'd0);
        mem_ready = 1'b0; opcode = ADD;
        cyc("hlt_2", S_HLT, 2'b00, 4'd0);
        cyc("hlt_3", S_HLT, 2'b00, 4'd0);
        #1 reset = 1'b1;
        #1 chk("hlt_rst", 32'(strobes), 32'(S_MR));
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        cyc("post_hlt_f", S_FET, 2'b00, 4'd0);
        cyc("post_hlt_d", 17'd0, 2'b00, 4'd0);
        cyc("post_hlt_e", S_EX, 2'b00, 4'd0);
        cyc("post_hlt_w", S_RW | S_LF, 2'b00, 4'd0);

`ifdef MCU_IRQ_EN
        irq = 1'b1;
        @(negedge clk);
        chk("irq_f_ack", 32'(irq_ack), 32'd0);
        @(posedge clk); #1;
        irq = 1'b0;
        @(negedge clk);
        chk("irq_ack", 32'(irq_ack), 32'd1);
        @(posedge clk); #1;
        opcode = SUB;
        @(negedge clk);
        chk("irq_ack_drop", 32'(irq_ack), 32'd0);
        @(posedge clk); #1;
        cyc("irq_sub_d", 17'd0, 2'b00, 4'd0);
        irq = 1'b1;
        @(negedge clk);
        chk("irq_exec_ack", 32'(irq_ack), 32'd0);
        @(posedge clk); #1;
        cyc("irq_sub_w", S_RW | S_LF, 2'b00, 4'd1);
        irq = 1'b0;
        cyc("irq_sub_next", S_FET, 2'b00, 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

`ifdef MCU_IRQ_EN
    // The IRQ cycle itself is checked here: vector load with pc_sel low.
    always @(negedge clk) begin
        if (!reset && irq_ack) begin
            chk("irq_state_strobes", 32'(strobes), 32'(S_LP));
        end
    end
`endif

endmodule
